cram_cond_seq: RTL
==================

// Module: cram_cond_seq
// PURPOSE
//  Sequencer for the CRAM condition-capture unit. On I_Start it requests one condition evaluation,
//  waits for the captured condition (valid + cond from the capture unit), then issues the
//  operation count of the selected branch (true/false) with a valid/ack handshake. Finally it
//  clears the capture unit for the next evaluation. Sits between the CRAM control front-end and
//  the condition-capture unit/branch datapath.
// PARAMETERS
//  WIDTH_CNT   8    width of branch-length and timeout counters
//  TIMEOUT     255  cycles waited in S_WAIT before abort (only with CRAM_COND_TIMEOUT_EN)
// PORTS
//  clock       in   1          single clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  I_Start     in   1          start one condition sequence; sampled only in S_IDLE
//  I_TrueLen   in   WIDTH_CNT  ops to issue if cond=1; latched on accepted I_Start
//  I_FalseLen  in   WIDTH_CNT  ops to issue if cond=0; latched on accepted I_Start
//  O_CondReq   out  1          one-cycle request to produce a back-prop condition token
//  I_Valid     in   1          capture unit holds a condition (its lock flag)
//  I_Cond      in   1          captured condition value
//  O_Clr       out  1          one-cycle clear to the capture unit
//  O_Issue     out  1          issue-valid for one branch op
//  I_Ack       in   1          downstream accepts op when O_Issue & I_Ack
//  O_Sel       out  1          selected branch (1 = true path); stable from S_EXEC until next capture
//  O_Busy      out  1          high in every state except S_IDLE
//  O_Done      out  1          one-cycle pulse: sequence finished (normal or timeout)
//  O_Timeout   out  1          one-cycle pulse with O_Done when the wait was aborted
// BEHAVIOUR
//  Reset (reset=0, async): state=S_IDLE, all outputs 0, counters and latched lengths 0.
//  FSM (registered; outputs decoded from state):
//   S_IDLE: I_Start=1 -> latch both lengths -> S_REQ.
//   S_REQ: O_CondReq=1 for exactly 1 cycle -> S_WAIT; timeout counter loaded with TIMEOUT.
//   S_WAIT: I_Valid=1 -> R_Sel<=I_Cond; load issue counter with the selected length.
//           Next state: length==0 -> S_CLR, else S_EXEC.
//           Timeout reaches 0 without I_Valid -> S_CLR with timeout flag set; O_Sel unchanged.
//           I_Valid on the same cycle the timeout hits 0: the capture wins.
//   S_EXEC: O_Issue=1. Each cycle with I_Ack=1 decrements the counter.
//           Ack taking the counter 1->0 -> S_CLR. O_Issue stays high while unacked (no drop).
//   S_CLR: O_Clr=1, O_Done=1, O_Timeout=timeout flag; all for 1 cycle -> S_IDLE; flag cleared.
//  Latency: I_Start at cycle 0 -> O_CondReq at cycle 1. I_Valid at cycle t -> O_Issue at t+1.
//   Last ack at t -> O_Clr/O_Done at t+1. Back-to-back starts are possible from the cycle after S_CLR.
//  I_Start outside S_IDLE is ignored (not queued). I_Ack outside S_EXEC is ignored.
//  I_Valid already high in S_REQ (stale lock) is not sampled; only S_WAIT captures.
//  Lengths are unsigned. Counters never wrap: decrement happens only when the counter is non-zero.
//  Reset asserted mid-sequence: immediate return to S_IDLE, all outputs 0, no O_Clr or O_Done.
// CONFIGURATION
//  CRAM_COND_TIMEOUT_EN defined: timeout counter present. S_WAIT aborts after TIMEOUT cycles;
//   O_Timeout can pulse.
//  Not defined: no timeout counter; S_WAIT waits indefinitely for I_Valid; O_Timeout tied 0.
// STRUCTURE
//  pkg_en: typedef enum logic [2:0] cond_seq_st_t {S_IDLE,S_REQ,S_WAIT,S_EXEC,S_CLR}.
//   The default TIMEOUT/WIDTH_CNT constants for CRAM live here.
//  Sub-module cram_cond_cnt: loadable down-counter (load, dec, zero flag, no wrap).
//   It is instanced once for the issue count and once for the timeout (timeout only under the macro).
// TESTING
//  1 I_Start, TrueLen=3, FalseLen=5, I_Valid=1 & I_Cond=1 in S_WAIT, I_Ack always 1
//    -> O_Sel=1, exactly 3 O_Issue&I_Ack cycles, then O_Clr=O_Done=1 for 1 cycle.
//  2 Same with I_Cond=0; I_Ack toggling 1,0,1,0...
//    -> 5 accepted ops; O_Issue never drops while unacked.
//  3 TrueLen=0, I_Cond=1 -> no O_Issue; O_Clr/O_Done one cycle after capture.
//  4 Macro on, TIMEOUT=4, I_Valid never set -> O_Done & O_Timeout pulse after 4 S_WAIT cycles.
//    Macro off -> FSM stays in S_WAIT, O_Busy=1.
//  5 I_Start pulsed during S_EXEC -> ignored.
//    reset=0 mid-S_EXEC -> all outputs 0 at once, then a fresh start works.
//  6 I_Valid high in S_REQ only, low in S_WAIT -> not captured; still waiting (or times out).

Source files
------------

// File: rtl/cram_cond_seq_pkg.sv
// Shared types and default constants for the CRAM condition sequencer.
// The timeout default only matters when CRAM_COND_TIMEOUT_EN is defined.
package cram_cond_seq_pkg;

  localparam int CRAM_WIDTH_CNT = 8;
  localparam int CRAM_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_CLR
  } cond_seq_st_t;

endpackage

// File: rtl/cram_cond_cnt.sv
// Loadable down-counter with a zero flag. It never wraps: a decrement
// request at zero is ignored, and a load takes priority over a decrement.
module cram_cond_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cram_cond_seq.sv
// Condition sequencer: request a condition, capture it, issue the selected
// branch's ops, then clear the capture unit. Macro CRAM_COND_TIMEOUT_EN adds the S_WAIT abort.
module cram_cond_seq
  import cram_cond_seq_pkg::*;
#(
  parameter int WIDTH_CNT = CRAM_WIDTH_CNT
`ifdef CRAM_COND_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = CRAM_TIMEOUT
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Start,
  input  logic [WIDTH_CNT-1:0] I_TrueLen,
  input  logic [WIDTH_CNT-1:0] I_FalseLen,
  output logic                 O_CondReq,
  input  logic                 I_Valid,
  input  logic                 I_Cond,
  output logic                 O_Clr,
  output logic                 O_Issue,
  input  logic                 I_Ack,
  output logic                 O_Sel,
  output logic                 O_Busy,
  output logic                 O_Done,
  output logic                 O_Timeout
);

  cond_seq_st_t         r_state;
  cond_seq_st_t         w_next;
  logic [WIDTH_CNT-1:0] r_true_len;
  logic [WIDTH_CNT-1:0] r_false_len;
  logic                 r_sel;
  logic [WIDTH_CNT-1:0] w_sel_len;
  logic [WIDTH_CNT-1:0] w_iss_load_val;
  logic                 w_capture;
  logic                 w_iss_zero;
  logic                 w_to_expire;
  logic                 w_to_flag;

  assign w_capture = (r_state == S_WAIT) && I_Valid;
  assign w_sel_len = I_Cond ? r_true_len : r_false_len;

  // The issue counter holds "ops remaining after the current one", so the
  // zero flag marks the last op and the counter never has to go below zero.
  assign w_iss_load_val = (w_sel_len == '0) ? '0 : w_sel_len - 1'b1;

  cram_cond_cnt #(.WIDTH(WIDTH_CNT)) u_iss_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_capture),
    .i_load_val (w_iss_load_val),
    .i_dec      ((r_state == S_EXEC) && I_Ack),
    .o_zero     (w_iss_zero)
  );

`ifdef CRAM_COND_TIMEOUT_EN
  // Loaded with TIMEOUT-1 in S_REQ so that zero is reached on the TIMEOUT-th
  // S_WAIT cycle; TIMEOUT is expected to be at least 1.
  localparam logic [WIDTH_CNT-1:0] TO_LOAD = WIDTH_CNT'(TIMEOUT - 1);

  logic w_to_zero;
  logic r_to_flag;

  cram_cond_cnt #(.WIDTH(WIDTH_CNT)) u_to_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (r_state == S_REQ),
    .i_load_val (TO_LOAD),
    .i_dec      (r_state == S_WAIT),
    .o_zero     (w_to_zero)
  );

  // A capture on the expiry cycle wins over the abort.
  assign w_to_expire = (r_state == S_WAIT) && !I_Valid && w_to_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_flag <= 1'b0;
    end else if (w_to_expire) begin
      r_to_flag <= 1'b1;
    end else if (r_state == S_CLR) begin
      r_to_flag <= 1'b0;
    end
  end

  assign w_to_flag = r_to_flag;
`else
  assign w_to_expire = 1'b0;
  assign w_to_flag   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_true_len  <= '0;
      r_false_len <= '0;
      r_sel       <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && I_Start) begin
        r_true_len  <= I_TrueLen;
        r_false_len <= I_FalseLen;
      end
      if (w_capture) begin
        r_sel <= I_Cond;
      end
    end
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (I_Start) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (I_Valid) begin
          w_next = (w_sel_len == '0) ? S_CLR : S_EXEC;
        end else if (w_to_expire) begin
          w_next = S_CLR;
        end
      end
      S_EXEC: if (I_Ack && w_iss_zero) w_next = S_CLR;
      S_CLR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign O_CondReq = (r_state == S_REQ);
  assign O_Issue   = (r_state == S_EXEC);
  assign O_Clr     = (r_state == S_CLR);
  assign O_Done    = (r_state == S_CLR);
  assign O_Timeout = (r_state == S_CLR) && w_to_flag;
  assign O_Busy    = (r_state != S_IDLE);
  assign O_Sel     = r_sel;

endmodule
